riscv_dmem: RTL and testbench

RISCV_DMEM -- requirements
Module: riscv_dmem

---
 rtl/riscv_dmem_if.sv | 31 +++
 rtl/riscv_dmem.sv | 145 ++++++++++++++
 tb/tb_riscv_dmem.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_dmem_if.sv
// Request/response bus between a RISC-V core load/store unit and the data memory.
// The core owns the request side; the memory owns the response side.
interface riscv_dmem_if;
    logic        dmem_en;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        dmem_err;

    modport master (
        output dmem_en,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ready,
        input  dmem_err
    );

    modport slave (
        input  dmem_en,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ready,
        output dmem_err
    );
endinterface

// File: rtl/riscv_dmem.sv
// Data memory with programmable wait states, a word RAM and a small MMIO window of
// saturating access counters (load / store / error) plus a clear register.
module riscv_dmem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    riscv_dmem_if.slave bus
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [31:0] MMIO_LAST = MMIO_BASE + 32'd12;
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      r_state, w_state_d;
    logic [3:0]  r_wcnt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic        r_ram_st, r_ram_ld, r_clr, r_err;
    logic [31:0] r_rdata;
    logic [31:0] r_load_cnt, r_store_cnt, r_err_cnt;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept, w_resp_entry;
    logic          w_req_we;
    logic [31:0]   w_req_addr;
    logic          w_is_ram, w_is_mmio, w_err;
    logic [1:0]    w_off;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_rdata;

    assign w_accept     = (r_state == StIdle) && bus.dmem_en;
    assign w_resp_entry = (w_state_d == StResp) && (r_state != StResp);

    // With zero wait states the response is resolved on the accept edge itself,
    // so decode from the live bus there and from the latched request otherwise.
    assign w_req_we   = (r_state == StIdle) ? bus.dmem_we   : r_we;
    assign w_req_addr = (r_state == StIdle) ? bus.dmem_addr : r_addr;

    assign w_is_ram  = w_req_addr < RAM_BYTES;
    assign w_is_mmio = (w_req_addr >= MMIO_BASE) && (w_req_addr <= MMIO_LAST);
    assign w_off     = 2'((w_req_addr - MMIO_BASE) >> 2);
    assign w_ram_idx = w_req_addr[AW+1:2];
    assign w_err     = (w_req_addr[1:0] != 2'd0) || !(w_is_ram || w_is_mmio) ||
                       (w_is_mmio && w_req_we && (w_off != 2'd3));

    always_comb begin
        w_rdata = '0;
        if (!w_err && !w_req_we) begin
            if (w_is_ram) begin
                w_rdata = r_mem[w_ram_idx];
            end else begin
                case (w_off)
                    2'd0:    w_rdata = r_load_cnt;
                    2'd1:    w_rdata = r_store_cnt;
                    2'd2:    w_rdata = r_err_cnt;
                    default: w_rdata = '0;
                endcase
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (bus.dmem_en) w_state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
            StWait:  if (r_wcnt == 4'd0) w_state_d = StResp;
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_ram_st    <= 1'b0;
            r_ram_ld    <= 1'b0;
            r_clr       <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_load_cnt  <= '0;
            r_store_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.dmem_we;
                r_addr  <= bus.dmem_addr;
                r_wdata <= bus.dmem_wdata;
                r_wcnt  <= WAIT_INIT;
            end else if ((r_state == StWait) && (r_wcnt != 4'd0)) begin
                r_wcnt <= r_wcnt - 4'd1;
            end

            if (w_resp_entry) begin
                r_rdata  <= w_rdata;
                r_err    <= w_err;
                r_ram_st <= !w_err && w_is_ram && w_req_we;
                r_ram_ld <= !w_err && w_is_ram && !w_req_we;
                r_clr    <= !w_err && w_is_mmio && w_req_we;
            end else if (r_state == StResp) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end

            // Counters commit on the edge that ends the response; clear wins.
            if (r_state == StResp) begin
                if (r_clr) begin
                    r_load_cnt  <= '0;
                    r_store_cnt <= '0;
                    r_err_cnt   <= '0;
                end else begin
                    if (r_ram_ld && (r_load_cnt != '1))  r_load_cnt  <= r_load_cnt + 32'd1;
                    if (r_ram_st && (r_store_cnt != '1)) r_store_cnt <= r_store_cnt + 32'd1;
                    if (r_err && (r_err_cnt != '1))      r_err_cnt   <= r_err_cnt + 32'd1;
                end
            end
        end
    end

    // RAM contents survive reset; a reset forces IDLE, which cancels any pending write.
    always_ff @(posedge clk) begin
        if ((r_state == StResp) && r_ram_st) begin
            r_mem[r_addr[AW+1:2]] <= r_wdata;
        end
    end

    assign bus.dmem_ready = (r_state == StResp);
    assign bus.dmem_rdata = r_rdata;
    assign bus.dmem_err   = r_err;
endmodule

// File: tb/tb_riscv_dmem.sv
// Directed bench for riscv_dmem: three instances with 0, 1 and 15 wait states share
// one request driver; the selected instance's response is compared with hand values.
module tb_riscv_dmem;
    localparam logic [31:0] MB = 32'h0001_0000;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        en    = 1'b0;
    logic        we    = 1'b0;
    logic [31:0] addr  = '0;
    logic [31:0] wdata = '0;
    int          sel   = 1;

    logic        obs_ready, obs_err;
    logic [31:0] obs_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    riscv_dmem_if b0 ();
    riscv_dmem_if b1 ();
    riscv_dmem_if b15 ();

    assign b0.dmem_en     = en && (sel == 0);
    assign b0.dmem_we     = we;
    assign b0.dmem_addr   = addr;
    assign b0.dmem_wdata  = wdata;
    assign b1.dmem_en     = en && (sel == 1);
    assign b1.dmem_we     = we;
    assign b1.dmem_addr   = addr;
    assign b1.dmem_wdata  = wdata;
    assign b15.dmem_en    = en && (sel == 2);
    assign b15.dmem_we    = we;
    assign b15.dmem_addr  = addr;
    assign b15.dmem_wdata = wdata;

    riscv_dmem #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    riscv_dmem #(.WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    riscv_dmem #(.WAIT_CYCLES(15)) u_dut15 (.clk(clk), .rst_n(rst_n), .bus(b15));

    always_comb begin
        obs_ready = b1.dmem_ready;
        obs_rdata = b1.dmem_rdata;
        obs_err   = b1.dmem_err;
        if (sel == 0) begin
            obs_ready = b0.dmem_ready;
            obs_rdata = b0.dmem_rdata;
            obs_err   = b0.dmem_err;
        end else if (sel == 2) begin
            obs_ready = b15.dmem_ready;
            obs_rdata = b15.dmem_rdata;
            obs_err   = b15.dmem_err;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, hold it until ready (bounded), then check latency,
    // response data/error and that ready drops after a single cycle.
    task automatic access(input int s, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input int lat,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int n;
        n     = 0;
        sel   = s;
        we    = w;
        addr  = a;
        wdata = d;
        en    = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!obs_ready && (n < 40));
        en = 1'b0;
        chk($sformatf("%s/lat", tag), 32'(n), 32'(lat));
        chk($sformatf("%s/rdata", tag), obs_rdata, exp_rd);
        chk($sformatf("%s/err", tag), {31'd0, obs_err}, {31'd0, exp_err});
        @(posedge clk);
        #1;
        chk($sformatf("%s/drop", tag),
            {30'd0, obs_ready, (obs_err || (obs_rdata != 32'd0))}, 32'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst/ready", {31'd0, obs_ready}, 32'd0);
        chk("rst/rdata", obs_rdata, 32'd0);
        chk("rst/err", {31'd0, obs_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic store/load and counter readback, 1 wait state
        access(1, 1'b1, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, "st10");
        access(1, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, "ld10");
        access(1, 1'b0, MB + 0, 32'h0, 2, 32'd1, 1'b0, "ldcnt1");
        access(1, 1'b0, MB + 4, 32'h0, 2, 32'd1, 1'b0, "stcnt1");
        access(1, 1'b0, MB + 8, 32'h0, 2, 32'd0, 1'b0, "errcnt0");

        // Misaligned and unmapped accesses
        access(1, 1'b0, 32'h13, 32'h0, 2, 32'h0, 1'b1, "ld13");
        access(1, 1'b1, 32'h0002_0000, 32'h55555555, 2, 32'h0, 1'b1, "stunm");
        access(1, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, "ld10b");
        access(1, 1'b0, MB + 8, 32'h0, 2, 32'd2, 1'b0, "errcnt2");
        access(1, 1'b0, MB + 0, 32'h0, 2, 32'd2, 1'b0, "ldcnt2");
        access(1, 1'b0, MB + 4, 32'h0, 2, 32'd1, 1'b0, "stcnt1b");

        // Read-only counter, RAM top word, just past RAM and past the MMIO window
        access(1, 1'b1, MB + 0, 32'h1, 2, 32'h0, 1'b1, "stro");
        access(1, 1'b0, MB + 8, 32'h0, 2, 32'd3, 1'b0, "errcnt3");
        access(1, 1'b1, 32'hFFC, 32'h12345678, 2, 32'h0, 1'b0, "sttop");
        access(1, 1'b0, 32'hFFC, 32'h0, 2, 32'h12345678, 1'b0, "ldtop");
        access(1, 1'b0, 32'h1000, 32'h0, 2, 32'h0, 1'b1, "ldpast");
        access(1, 1'b0, MB + 16, 32'h0, 2, 32'h0, 1'b1, "ldmmio16");

        // Five more RAM loads, then clear via +12
        for (int i = 0; i < 5; i++) begin
            access(1, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0, $sformatf("ld5_%0d", i));
        end
        access(1, 1'b0, MB + 0, 32'h0, 2, 32'd8, 1'b0, "ldcnt8");
        access(1, 1'b1, MB + 12, 32'h0, 2, 32'h0, 1'b0, "clr");
        access(1, 1'b0, MB + 0, 32'h0, 2, 32'd0, 1'b0, "ldcnt_clr");
        access(1, 1'b0, MB + 4, 32'h0, 2, 32'd0, 1'b0, "stcnt_clr");
        access(1, 1'b0, MB + 8, 32'h0, 2, 32'd0, 1'b0, "errcnt_clr");
        access(1, 1'b0, MB + 12, 32'h0, 2, 32'd0, 1'b0, "ld12");

        // Reset during WAIT of a store
        access(1, 1'b1, 32'h20, 32'h11111111, 2, 32'h0, 1'b0, "st20");
        sel   = 1;
        we    = 1'b1;
        addr  = 32'h20;
        wdata = 32'h22222222;
        en    = 1'b1;
        @(posedge clk);
        #1;
        chk("midwait/ready", {31'd0, obs_ready}, 32'd0);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("inrst/ready", {31'd0, obs_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("postrst_ready%0d", i), {31'd0, obs_ready}, 32'd0);
        end
        access(1, 1'b0, 32'h20, 32'h0, 2, 32'h11111111, 1'b0, "ld20");
        access(1, 1'b0, MB + 4, 32'h0, 2, 32'd0, 1'b0, "stcnt_rst");

        // Zero wait states, back-to-back loads with the request held
        access(0, 1'b1, 32'h10, 32'hCAFEF00D, 1, 32'h0, 1'b0, "w0st");
        sel  = 0;
        we   = 1'b0;
        addr = 32'h10;
        en   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b2b_ready%0d", i), {31'd0, obs_ready}, {31'd0, (i % 2) == 0});
            if ((i % 2) == 0) chk($sformatf("b2b_rdata%0d", i), obs_rdata, 32'hCAFEF00D);
        end
        en = 1'b0;
        @(posedge clk);
        #1;

        // Fifteen wait states
        access(2, 1'b1, 32'h40, 32'hA5A5A5A5, 16, 32'h0, 1'b0, "w15st");
        access(2, 1'b0, 32'h40, 32'h0, 16, 32'hA5A5A5A5, 1'b0, "w15ld");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
